// File: rtl/mac_dot_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// mac_dot_sequencer_pkg
// Definitions shared by the dot-product sequencer and its result formatter:
//   - state_t        : sequencer FSM encoding (IDLE / ISSUE / DRAIN)
//   - MAC_PIPE_LAT   : stages in the shared MAC (a/b reg, mult reg, accumulator)
//   - MAC_*_W        : MAC operand, product and accumulator widths
//   - RES_MAX/RES_MIN: limits of the 18-bit signed result
// -----------------------------------------------------------------------------
package mac_dot_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int MAC_PIPE_LAT = 3;
    localparam int MAC_IN_W     = 18;
    localparam int MAC_PROD_W   = 36;
    localparam int MAC_ACC_W    = 48;

    localparam logic signed [MAC_IN_W-1:0] RES_MAX = 18'sh1FFFF;  //  131071
    localparam logic signed [MAC_IN_W-1:0] RES_MIN = 18'sh20000;  // -131072

endpackage

// File: rtl/mac_shift_sat.sv
// -----------------------------------------------------------------------------
// mac_shift_sat
// Combinational result formatter: arithmetic right shift of the 48-bit
// accumulator by SHIFT, then saturation to the 18-bit signed range.
// Ports:
//   acc_in   in   48  signed accumulator value
//   sat_out  out  18  shifted and saturated value
//   sat_flag out  1   high when the shifted value was clipped
// -----------------------------------------------------------------------------
module mac_shift_sat
    import mac_dot_sequencer_pkg::*;
#(
    parameter int SHIFT = 17
) (
    input  logic signed [MAC_ACC_W-1:0] acc_in,
    output logic signed [MAC_IN_W-1:0]  sat_out,
    output logic                        sat_flag
);

    localparam logic signed [MAC_ACC_W-1:0] HI_EXT = MAC_ACC_W'(RES_MAX);
    localparam logic signed [MAC_ACC_W-1:0] LO_EXT = MAC_ACC_W'(RES_MIN);

    logic signed [MAC_ACC_W-1:0] shifted;

    assign shifted = acc_in >>> SHIFT;

    always_comb begin
        sat_out  = shifted[MAC_IN_W-1:0];
        sat_flag = 1'b0;
        if (shifted > HI_EXT) begin
            sat_out  = RES_MAX;
            sat_flag = 1'b1;
        end else if (shifted < LO_EXT) begin
            sat_out  = RES_MIN;
            sat_flag = 1'b1;
        end
    end

endmodule

// File: rtl/mac_dot_sequencer.sv
// -----------------------------------------------------------------------------
// mac_dot_sequencer
// Drives one shared 18x18 signed MAC through a TAPS-point dot product of the
// coefficient and sample memories, one product per clock, and returns the
// 48-bit sum plus an 18-bit shifted/saturated copy with a one-cycle strobe.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   start, abort            job request (idle only) / cancel of running job
//   busy                    job in progress
//   coefAddr, dataAddr      registered memory read address (identical)
//   coefIn, sampleIn        memory read data, MEM_LAT cycles after address
//   macA, macB              pass-through of coefIn / sampleIn to the MAC
//   macAcc, macAccClr,      MAC controls (registered)
//   macSclr
//   macP                    MAC accumulator output
//   resultFull, result,     captured sum, shifted/saturated sum, clip flag
//   resultSat
//   resultValid             one-cycle strobe when the result* outputs update
// -----------------------------------------------------------------------------
module mac_dot_sequencer
    import mac_dot_sequencer_pkg::*;
#(
    parameter int TAPS    = 16,
    parameter int ADDR_W  = 4,
    parameter int MEM_LAT = 1,
    parameter int SHIFT   = 17
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic                        abort,
    output logic                        busy,
    output logic [ADDR_W-1:0]           coefAddr,
    output logic [ADDR_W-1:0]           dataAddr,
    input  logic signed [MAC_IN_W-1:0]  coefIn,
    input  logic signed [MAC_IN_W-1:0]  sampleIn,
    output logic signed [MAC_IN_W-1:0]  macA,
    output logic signed [MAC_IN_W-1:0]  macB,
    output logic                        macAcc,
    output logic                        macAccClr,
    output logic                        macSclr,
    input  logic signed [MAC_ACC_W-1:0] macP,
    output logic signed [MAC_ACC_W-1:0] resultFull,
    output logic signed [MAC_IN_W-1:0]  result,
    output logic                        resultSat,
    output logic                        resultValid
);

    // A tap's product reaches the MAC mult register this many cycles after
    // its address is presented: memory latency plus the a/b and mult stages.
    localparam int TAG_DEPTH = MEM_LAT + MAC_PIPE_LAT - 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TAPS - 1);

    state_t                       state_reg;
    logic [ADDR_W-1:0]            addr_reg;
    logic                         busy_reg;
    logic                         acc_clr_reg;
    logic                         sclr_reg;
    logic                         valid_reg;
    logic                         sat_reg;
    logic signed [MAC_ACC_W-1:0]  full_reg;
    logic signed [MAC_IN_W-1:0]   result_reg;

    // acc tag: product present and not the first tap of the job.
    // last tag: runs one stage further so it fires in the cycle macP holds
    // the complete sum.
    logic [TAG_DEPTH-1:0]         acc_pipe_reg;
    logic [TAG_DEPTH:0]           last_pipe_reg;

    logic                         issuing;
    logic                         flush;
    logic                         accept;
    logic                         issue_acc;
    logic                         issue_last;
    logic                         capture;
    logic signed [MAC_IN_W-1:0]   sat_value;
    logic                         sat_flag;

    assign issuing    = (state_reg == ST_ISSUE);
    assign flush      = abort && (state_reg != ST_IDLE);
    // abort wins over a simultaneous start, even when idle
    assign accept     = start && !abort && (state_reg == ST_IDLE);
    assign issue_acc  = issuing && (addr_reg != '0);
    assign issue_last = issuing && (addr_reg == LAST_ADDR);
    assign capture    = last_pipe_reg[TAG_DEPTH] && !flush;

    mac_shift_sat #(
        .SHIFT(SHIFT)
    ) u_shift_sat (
        .acc_in  (macP),
        .sat_out (sat_value),
        .sat_flag(sat_flag)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_pipe_reg  <= '0;
            last_pipe_reg <= '0;
        end else if (flush) begin
            acc_pipe_reg  <= '0;
            last_pipe_reg <= '0;
        end else begin
            acc_pipe_reg  <= {acc_pipe_reg[TAG_DEPTH-2:0], issue_acc};
            last_pipe_reg <= {last_pipe_reg[TAG_DEPTH-1:0], issue_last};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= ST_IDLE;
            addr_reg    <= '0;
            busy_reg    <= 1'b0;
            acc_clr_reg <= 1'b1;
            sclr_reg    <= 1'b0;
            valid_reg   <= 1'b0;
            sat_reg     <= 1'b0;
            full_reg    <= '0;
            result_reg  <= '0;
        end else begin
            sclr_reg  <= 1'b0;
            valid_reg <= 1'b0;
            if (flush) begin
                state_reg   <= ST_IDLE;
                busy_reg    <= 1'b0;
                acc_clr_reg <= 1'b1;
                sclr_reg    <= 1'b1;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (accept) begin
                            state_reg   <= ST_ISSUE;
                            addr_reg    <= '0;
                            busy_reg    <= 1'b1;
                            acc_clr_reg <= 1'b0;
                        end
                    end
                    ST_ISSUE: begin
                        // address stops at the last tap and holds there
                        if (addr_reg == LAST_ADDR) begin
                            state_reg <= ST_DRAIN;
                        end else begin
                            addr_reg <= addr_reg + ADDR_W'(1);
                        end
                    end
                    ST_DRAIN: begin
                        if (capture) begin
                            state_reg   <= ST_IDLE;
                            busy_reg    <= 1'b0;
                            acc_clr_reg <= 1'b1;
                            valid_reg   <= 1'b1;
                            full_reg    <= macP;
                            result_reg  <= sat_value;
                            sat_reg     <= sat_flag;
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    assign busy        = busy_reg;
    assign coefAddr    = addr_reg;
    assign dataAddr    = addr_reg;
    assign macA        = coefIn;
    assign macB        = sampleIn;
    assign macAcc      = acc_pipe_reg[TAG_DEPTH-1];
    assign macAccClr   = acc_clr_reg;
    assign macSclr     = sclr_reg;
    assign resultFull  = full_reg;
    assign result      = result_reg;
    assign resultSat   = sat_reg;
    assign resultValid = valid_reg;

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mac_dot_sequencer
// Directed bench: two sequencers (SHIFT=0 and SHIFT=17) share one model of
// the coefficient/sample memories (1-cycle read) and of the 3-stage MAC.
// -----------------------------------------------------------------------------
module tb_mac_dot_sequencer;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic start   = 1'b0;
    logic abort   = 1'b0;

    logic signed [17:0] coefIn   = '0;
    logic signed [17:0] sampleIn = '0;
    logic signed [47:0] macP     = '0;

    logic               busy, macAcc, macAccClr, macSclr, resultSat, resultValid;
    logic [3:0]         coefAddr, dataAddr;
    logic signed [17:0] macA, macB, result;
    logic signed [47:0] resultFull;

    logic               s17_busy, s17_macAcc, s17_macAccClr, s17_macSclr;
    logic               s17_resultSat, s17_resultValid;
    logic [3:0]         s17_coefAddr, s17_dataAddr;
    logic signed [17:0] s17_macA, s17_macB, s17_result;
    logic signed [47:0] s17_resultFull;

    logic signed [17:0] coef_mem [16];
    logic signed [17:0] samp_mem [16];
    logic signed [17:0] a_r = '0;
    logic signed [17:0] b_r = '0;
    logic signed [35:0] m_r = '0;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int vcyc0, vcyc1, vcount;
    logic [63:0] acc_mask, busy_mask, sclr_mask, clr_mask;

    mac_dot_sequencer #(.TAPS(16), .ADDR_W(4), .MEM_LAT(1), .SHIFT(0)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .busy(busy), .coefAddr(coefAddr), .dataAddr(dataAddr),
        .coefIn(coefIn), .sampleIn(sampleIn), .macA(macA), .macB(macB),
        .macAcc(macAcc), .macAccClr(macAccClr), .macSclr(macSclr), .macP(macP),
        .resultFull(resultFull), .result(result), .resultSat(resultSat),
        .resultValid(resultValid)
    );

    mac_dot_sequencer #(.TAPS(16), .ADDR_W(4), .MEM_LAT(1), .SHIFT(17)) u_dut17 (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .busy(s17_busy), .coefAddr(s17_coefAddr), .dataAddr(s17_dataAddr),
        .coefIn(coefIn), .sampleIn(sampleIn), .macA(s17_macA), .macB(s17_macB),
        .macAcc(s17_macAcc), .macAccClr(s17_macAccClr), .macSclr(s17_macSclr),
        .macP(macP), .resultFull(s17_resultFull), .result(s17_result),
        .resultSat(s17_resultSat), .resultValid(s17_resultValid)
    );

    always #5 clk = ~clk;

    // memories: registered read, one cycle latency
    always @(posedge clk) begin
        coefIn   <= coef_mem[coefAddr];
        sampleIn <= samp_mem[dataAddr];
    end

    // MAC: a/b reg, mult reg, 48b accumulator (acc=0 loads, acc=1 adds)
    always @(posedge clk) begin
        if (macSclr) begin
            a_r  <= '0;
            b_r  <= '0;
            m_r  <= '0;
            macP <= '0;
        end else begin
            a_r <= macA;
            b_r <= macB;
            m_r <= a_r * b_r;
            if (macAccClr)
                macP <= '0;
            else if (macAcc)
                macP <= macP + $signed({{12{m_r[35]}}, m_r});
            else
                macP <= $signed({{12{m_r[35]}}, m_r});
        end
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string p);
        chk({p, "_busy"},  longint'(busy), 0);
        chk({p, "_caddr"}, longint'(coefAddr), 0);
        chk({p, "_daddr"}, longint'(dataAddr), 0);
        chk({p, "_acc"},   longint'(macAcc), 0);
        chk({p, "_clr"},   longint'(macAccClr), 1);
        chk({p, "_sclr"},  longint'(macSclr), 0);
        chk({p, "_valid"}, longint'(resultValid), 0);
        chk({p, "_sat"},   longint'(resultSat), 0);
        chk({p, "_res"},   longint'(result), 0);
        chk({p, "_full"},  longint'(resultFull), 0);
    endtask

    // Start a job (start sampled at edge E), then observe cycles 0..n-1.
    // restart_at / abort_at drive start / abort high during that cycle.
    task automatic run_job(input int n, input int restart_at, input int abort_at);
        start = 1'b1;
        tick();
        start = 1'b0;
        vcyc0 = -1; vcyc1 = -1; vcount = 0;
        acc_mask = '0; busy_mask = '0; sclr_mask = '0; clr_mask = '0;
        for (int c = 0; c < n; c++) begin
            start = (c == restart_at);
            abort = (c == abort_at);
            acc_mask[c]  = macAcc;
            busy_mask[c] = busy;
            sclr_mask[c] = macSclr;
            clr_mask[c]  = macAccClr;
            if (resultValid) begin
                if (vcount == 0) vcyc0 = c;
                else if (vcount == 1) vcyc1 = c;
                vcount++;
            end
            tick();
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        check_reset("por");
        tick();

        // all coef=1, samples=1000
        for (int k = 0; k < 16; k++) begin coef_mem[k] = 18'sd1; samp_mem[k] = 18'sd1000; end
        run_job(24, -1, -1);
        $display("job ones: full=%0d result=%0d sat=%0d valid_cycle=%0d", resultFull, result, resultSat, vcyc0);
        chk("ones_vcyc",  vcyc0, 20);
        chk("ones_vcnt",  vcount, 1);
        chk("ones_busy",  longint'(busy_mask[23:0]), 64'h0F_FFFF);
        chk("ones_acc",   longint'(acc_mask[23:0]),  64'h07_FFF0);
        chk("ones_clr",   longint'(clr_mask[23:0]),  64'hF0_0000);
        chk("ones_full",  longint'(resultFull), 16000);
        chk("ones_res",   longint'(result), 16000);
        chk("ones_sat",   longint'(resultSat), 0);
        chk("ones_res17", longint'(s17_result), 0);

        // coef=k, sample=k, back-to-back restart in the resultValid cycle
        for (int k = 0; k < 16; k++) begin coef_mem[k] = 18'(k); samp_mem[k] = 18'(k); end
        run_job(48, 20, -1);
        $display("job squares b2b: full=%0d valid_cycles=%0d,%0d", resultFull, vcyc0, vcyc1);
        chk("sq_vcyc0",  vcyc0, 20);
        chk("sq_vcyc1",  vcyc1, 41);
        chk("sq_vcnt",   vcount, 2);
        chk("sq_busy20", longint'(busy_mask[20]), 0);
        chk("sq_busy21", longint'(busy_mask[21]), 1);
        chk("sq_full",   longint'(resultFull), 1240);
        chk("sq_res",    longint'(result), 1240);

        // positive saturation; extra start while busy must be ignored
        for (int k = 0; k < 16; k++) begin coef_mem[k] = 18'sd131071; samp_mem[k] = 18'sd131071; end
        run_job(30, 8, -1);
        $display("job max: full=%0d result=%0d sat=%0d valids=%0d", resultFull, result, resultSat, vcount);
        chk("max_vcnt", vcount, 1);
        chk("max_vcyc", vcyc0, 20);
        chk("max_full", longint'(resultFull), 64'sd274873712656);
        chk("max_res",  longint'(result), 131071);
        chk("max_sat",  longint'(resultSat), 1);

        // negative saturation, both shifts
        for (int k = 0; k < 16; k++) begin coef_mem[k] = -18'sd131072; samp_mem[k] = 18'sd131071; end
        run_job(24, -1, -1);
        $display("job min: full=%0d result=%0d sat=%0d result17=%0d", resultFull, result, resultSat, s17_result);
        chk("min_full",  longint'(resultFull), -64'sd274875809792);
        chk("min_res",   longint'(result), -131072);
        chk("min_sat",   longint'(resultSat), 1);
        chk("min_res17", longint'(s17_result), -131072);
        chk("min_sat17", longint'(s17_resultSat), 1);

        // single product: SHIFT=0 clips, SHIFT=17 is exact
        for (int k = 0; k < 16; k++) begin coef_mem[k] = '0; samp_mem[k] = '0; end
        coef_mem[0] = -18'sd131072;
        samp_mem[0] = 18'sd131071;
        run_job(24, -1, -1);
        $display("job single: full=%0d result=%0d result17=%0d sat17=%0d", resultFull, result, s17_result, s17_resultSat);
        chk("one_full",  longint'(resultFull), -64'sd17179738112);
        chk("one_res",   longint'(result), -131072);
        chk("one_sat",   longint'(resultSat), 1);
        chk("one_res17", longint'(s17_result), -131071);
        chk("one_sat17", longint'(s17_resultSat), 0);

        // abort in cycle 5, then a clean restart
        for (int k = 0; k < 16; k++) begin coef_mem[k] = 18'sd1; samp_mem[k] = 18'sd1000; end
        run_job(30, -1, 5);
        $display("job abort: valids=%0d busy_mask=%0h sclr_mask=%0h", vcount, busy_mask[29:0], sclr_mask[29:0]);
        chk("abort_vcnt", vcount, 0);
        chk("abort_busy", longint'(busy_mask[29:0]), 64'h3F);
        chk("abort_sclr", longint'(sclr_mask[29:0]), 64'h40);
        chk("abort_hold", longint'(resultFull), -64'sd17179738112);
        run_job(24, -1, -1);
        $display("job after abort: full=%0d valid_cycle=%0d", resultFull, vcyc0);
        chk("rest_full", longint'(resultFull), 16000);
        chk("rest_vcyc", vcyc0, 20);

        // abort together with start while idle: start ignored
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        $display("idle abort+start: busy=%0d", busy);
        chk("idle_abort_busy", longint'(busy), 0);

        // asynchronous reset in cycle 8 of a job
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        chk("arst_pre_busy", longint'(busy), 1);
        reset_n = 1'b0;
        #1;
        $display("async reset mid-job: busy=%0d addr=%0d full=%0d", busy, coefAddr, resultFull);
        check_reset("arst");
        tick();
        reset_n = 1'b1;
        vcount = 0;
        for (int c = 0; c < 30; c++) begin
            if (resultValid) vcount++;
            tick();
        end
        chk("arst_no_valid", vcount, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
